// File: rtl/msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : msg_scheduler
// Purpose  : Round-robin arbiter for two order-message sources feeding a
//            DEPTH-entry FIFO, with an optional single-step release mode
//            driven by a push-button (next_msg).
// Ports    :
//   clk, rst                  clock, asynchronous active-low reset
//   src0_valid/msg/ready      source 0 (ROM feeder) handshake
//   src1_valid/msg/ready      source 1 (host receiver) handshake
//   step_mode, next_msg       single-step enable and release button
//   out_valid/msg/ready       consumer handshake, out_msg = FIFO head
//   level                     FIFO occupancy
//   issued_count              messages delivered, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module msg_scheduler #(
  parameter int DEPTH = 4,
  parameter int MSG_W = 168
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     src0_valid,
  input  logic [MSG_W-1:0]         src0_msg,
  output logic                     src0_ready,
  input  logic                     src1_valid,
  input  logic [MSG_W-1:0]         src1_msg,
  output logic                     src1_ready,
  input  logic                     step_mode,
  input  logic                     next_msg,
  output logic                     out_valid,
  output logic [MSG_W-1:0]         out_msg,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [MSG_W-1:0] mem_q [DEPTH];
  logic [MSG_W-1:0] mem_d [DEPTH];
  logic             full_q, full_d;
  logic             last_grant_q, last_grant_d;
  logic             credit_q, credit_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [15:0]      issued_q, issued_d;

  logic             empty;
  logic             grant;
  logic             push;
  logic             pop;
  logic             press;
  logic [MSG_W-1:0] push_msg;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);

    // Contention goes to whichever source did not win the last transfer.
    grant = 1'b0;
    if (src0_valid && src1_valid) begin
      grant = ~last_grant_q;
    end else if (src1_valid) begin
      grant = 1'b1;
    end

    // Readies are gated by rst so nothing is accepted while reset is held.
    src0_ready = rst && src0_valid && !grant && !full_q;
    src1_ready = rst && src1_valid &&  grant && !full_q;
    push       = src0_ready || src1_ready;
    push_msg   = src1_ready ? src1_msg : src0_msg;

    press     = sync2_q && !prev_q;
    out_valid = rst && !empty && (!step_mode || credit_q);
    pop       = out_valid && out_ready;

    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
               (wr_ptr_d[AW] != rd_ptr_d[AW]);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_msg;
    end

    last_grant_d = last_grant_q;
    if (push) begin
      last_grant_d = src1_ready;
    end

    // A press wins over a same-cycle pop so that press is never lost to it.
    credit_d = 1'b0;
    if (step_mode) begin
      if (press) begin
        credit_d = 1'b1;
      end else if (pop) begin
        credit_d = 1'b0;
      end else begin
        credit_d = credit_q;
      end
    end

    issued_d = issued_q + {15'd0, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      full_q       <= 1'b0;
      last_grant_q <= 1'b1;
      credit_q     <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      issued_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      full_q       <= full_d;
      last_grant_q <= last_grant_d;
      credit_q     <= credit_d;
      sync1_q      <= next_msg;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      issued_q     <= issued_d;
      mem_q        <= mem_d;
    end
  end

  assign out_msg      = mem_q[rd_ptr_q[AW-1:0]];
  assign level        = wr_ptr_q - rd_ptr_q;
  assign issued_count = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_scheduler
// Purpose  : Directed self-checking bench for msg_scheduler (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_scheduler;
  localparam int DEPTH = 4;
  localparam int MSG_W = 168;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             src0_valid = 1'b0;
  logic [MSG_W-1:0] src0_msg = '0;
  logic             src0_ready;
  logic             src1_valid = 1'b0;
  logic [MSG_W-1:0] src1_msg = '0;
  logic             src1_ready;
  logic             step_mode = 1'b0;
  logic             next_msg = 1'b0;
  logic             out_valid;
  logic [MSG_W-1:0] out_msg;
  logic             out_ready = 1'b0;
  logic [2:0]       level;
  logic [15:0]      issued_count;

  int passed = 0;
  int total  = 0;

  msg_scheduler #(.DEPTH(DEPTH), .MSG_W(MSG_W)) dut (
    .clk(clk), .rst(rst),
    .src0_valid(src0_valid), .src0_msg(src0_msg), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_msg(src1_msg), .src1_ready(src1_ready),
    .step_mode(step_mode), .next_msg(next_msg),
    .out_valid(out_valid), .out_msg(out_msg), .out_ready(out_ready),
    .level(level), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    src0_valid = 0; src1_valid = 0; out_ready = 0; step_mode = 0; next_msg = 0;
    rst = 0;
    tick; tick;
    rst = 1;
  endtask

  task automatic test_reset;
    rst = 0; src0_valid = 1; src1_valid = 1;
    tick; tick; tick;
    total++;
    if ({src0_ready, src1_ready, out_valid, level, issued_count} !== 22'd0 || out_msg !== '0)
      $display("FAIL reset_outputs: got rdy=%b%b ov=%b lvl=%0d cnt=%0d msg=%h expected all 0",
               src0_ready, src1_ready, out_valid, level, issued_count, out_msg);
    else passed++;
    src0_valid = 0; src1_valid = 0; rst = 1;
    for (int c = 0; c < 10; c++) begin
      tick;
      total++;
      if ({src0_ready, src1_ready, out_valid, level, issued_count} !== 22'd0 || out_msg !== '0)
        $display("FAIL idle_outputs c=%0d: got rdy=%b%b ov=%b lvl=%0d cnt=%0d expected all 0",
                 c, src0_ready, src1_ready, out_valid, level, issued_count);
      else passed++;
    end
  endtask

  task automatic test_contention;
    logic [MSG_W-1:0] q[$];
    int n0, n1;
    bit p0, p1, pp;
    do_reset;
    n0 = 0; n1 = 0; out_ready = 1;
    for (int c = 0; c < 20 && (c < 8 || q.size() > 0); c++) begin
      src0_valid = (c < 8); src1_valid = (c < 8);
      src0_msg = MSG_W'(32'hA0 + n0);
      src1_msg = MSG_W'(32'hB0 + n1);
      #1;
      p0 = (c < 8) && (c % 2 == 0);
      p1 = (c < 8) && (c % 2 == 1);
      total++;
      if ({src0_ready, src1_ready} !== {p0, p1})
        $display("FAIL rr_grant c=%0d: got %b%b expected %b%b", c, src0_ready, src1_ready, p0, p1);
      else passed++;
      pp = (q.size() > 0);
      total++;
      if (out_valid !== pp)
        $display("FAIL rr_out_valid c=%0d: got %b expected %b", c, out_valid, pp);
      else passed++;
      if (pp) begin
        total++;
        if (out_msg !== q[0])
          $display("FAIL rr_order c=%0d: got %h expected %h", c, out_msg, q[0]);
        else passed++;
      end
      tick;
      if (pp) void'(q.pop_front());
      if (p0) begin q.push_back(src0_msg); n0++; end
      if (p1) begin q.push_back(src1_msg); n1++; end
    end
    src0_valid = 0; src1_valid = 0;
    total++;
    if (issued_count !== 16'd8)
      $display("FAIL rr_issued: got %0d expected 8", issued_count);
    else passed++;
  endtask

  task automatic test_backpressure;
    do_reset;
    src0_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      src0_msg = MSG_W'(k);
      #1;
      total++;
      if (src0_ready !== 1'b1) $display("FAIL bp_fill_ready k=%0d: got %b expected 1", k, src0_ready);
      else passed++;
      tick;
    end
    src0_msg = MSG_W'(5);
    #1;
    total++;
    if (level !== 3'd4 || src0_ready !== 1'b0)
      $display("FAIL bp_full: got lvl=%0d rdy=%b expected lvl=4 rdy=0", level, src0_ready);
    else passed++;
    out_ready = 1;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_msg !== MSG_W'(1) || src0_ready !== 1'b0)
      $display("FAIL bp_pop: got ov=%b msg=%h rdy=%b expected ov=1 msg=1 rdy=0",
               out_valid, out_msg, src0_ready);
    else passed++;
    tick;
    out_ready = 0;
    #1;
    total++;
    if (level !== 3'd3 || src0_ready !== 1'b1 || out_msg !== MSG_W'(2))
      $display("FAIL bp_after_pop: got lvl=%0d rdy=%b msg=%h expected lvl=3 rdy=1 msg=2",
               level, src0_ready, out_msg);
    else passed++;
    tick;
    src0_msg = MSG_W'(6);
    #1;
    total++;
    if (level !== 3'd4 || src0_ready !== 1'b0)
      $display("FAIL bp_refull: got lvl=%0d rdy=%b expected lvl=4 rdy=0", level, src0_ready);
    else passed++;
    src0_valid = 0;
  endtask

  task automatic test_simul_push_pop;
    do_reset;
    src0_valid = 1;
    src0_msg = MSG_W'(32'h11); tick;
    src0_msg = MSG_W'(32'h22); tick;
    src0_msg = MSG_W'(32'h33); out_ready = 1;
    #1;
    total++;
    if (level !== 3'd2 || src0_ready !== 1'b1 || out_valid !== 1'b1 || out_msg !== MSG_W'(32'h11))
      $display("FAIL sim_before: got lvl=%0d rdy=%b ov=%b msg=%h expected lvl=2 rdy=1 ov=1 msg=11",
               level, src0_ready, out_valid, out_msg);
    else passed++;
    tick;
    src0_valid = 0;
    #1;
    total++;
    if (level !== 3'd2 || out_msg !== MSG_W'(32'h22))
      $display("FAIL sim_level: got lvl=%0d msg=%h expected lvl=2 msg=22", level, out_msg);
    else passed++;
    tick;
    total++;
    if (level !== 3'd1 || out_msg !== MSG_W'(32'h33))
      $display("FAIL sim_order: got lvl=%0d msg=%h expected lvl=1 msg=33", level, out_msg);
    else passed++;
    tick;
    total++;
    if (level !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL sim_drain: got lvl=%0d ov=%b expected 0 0", level, out_valid);
    else passed++;
    out_ready = 0;
  endtask

  task automatic test_step_mode;
    do_reset;
    src1_valid = 1;
    src1_msg = MSG_W'(32'h51); tick;
    src1_msg = MSG_W'(32'h52); tick;
    src1_msg = MSG_W'(32'h53); tick;
    src1_valid = 0; step_mode = 1; out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (out_valid !== 1'b0 || level !== 3'd3)
        $display("FAIL step_hold c=%0d: got ov=%b lvl=%0d expected ov=0 lvl=3", c, out_valid, level);
      else passed++;
      tick;
    end
    next_msg = 1; tick; next_msg = 0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL step_lat1: got %b expected 0", out_valid);
    else passed++;
    tick;
    total++;
    if (out_valid !== 1'b0) $display("FAIL step_lat2: got %b expected 0", out_valid);
    else passed++;
    tick;
    total++;
    if (out_valid !== 1'b1 || out_msg !== MSG_W'(32'h51))
      $display("FAIL step_release: got ov=%b msg=%h expected ov=1 msg=51", out_valid, out_msg);
    else passed++;
    tick;
    total++;
    if (out_valid !== 1'b0 || level !== 3'd2)
      $display("FAIL step_one_only: got ov=%b lvl=%0d expected ov=0 lvl=2", out_valid, level);
    else passed++;
    out_ready = 0;
    next_msg = 1; tick; next_msg = 0; tick; tick;
    total++;
    if (out_valid !== 1'b1) $display("FAIL step_credit: got %b expected 1", out_valid);
    else passed++;
    tick;
    next_msg = 1; tick; next_msg = 0; tick; tick; tick;
    total++;
    if (out_valid !== 1'b1 || level !== 3'd2)
      $display("FAIL step_second_press: got ov=%b lvl=%0d expected ov=1 lvl=2", out_valid, level);
    else passed++;
    out_ready = 1;
    #1;
    total++;
    if (out_msg !== MSG_W'(32'h52)) $display("FAIL step_msg2: got %h expected 52", out_msg);
    else passed++;
    tick;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (out_valid !== 1'b0 || level !== 3'd1)
        $display("FAIL step_lost_press c=%0d: got ov=%b lvl=%0d expected ov=0 lvl=1", c, out_valid, level);
      else passed++;
      tick;
    end
    step_mode = 0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_msg !== MSG_W'(32'h53))
      $display("FAIL step_exit: got ov=%b msg=%h expected ov=1 msg=53", out_valid, out_msg);
    else passed++;
    tick;
    total++;
    if (level !== 3'd0) $display("FAIL step_drain: got lvl=%0d expected 0", level);
    else passed++;
    out_ready = 0;
  endtask

  task automatic test_wrap_and_reset;
    int cyc;
    do_reset;
    src0_valid = 1; out_ready = 1; src0_msg = MSG_W'(32'h77);
    cyc = 0;
    while (issued_count !== 16'hFFFF && cyc < 70000) begin
      tick;
      cyc++;
    end
    total++;
    if (issued_count !== 16'hFFFF)
      $display("FAIL wrap_reach: got %h expected ffff (cycle budget expired)", issued_count);
    else passed++;
    src0_valid = 0;
    #1;
    total++;
    if (out_valid !== 1'b1) $display("FAIL wrap_pending: got ov=%b expected 1", out_valid);
    else passed++;
    tick;
    total++;
    if (issued_count !== 16'h0000 || level !== 3'd0)
      $display("FAIL wrap_value: got cnt=%h lvl=%0d expected cnt=0000 lvl=0", issued_count, level);
    else passed++;
    out_ready = 0; src0_valid = 1;
    tick; tick; tick;
    src0_valid = 0;
    #1;
    total++;
    if (level !== 3'd3) $display("FAIL areset_pre: got lvl=%0d expected 3", level);
    else passed++;
    #1 rst = 0;
    #1;
    total++;
    if (level !== 3'd0 || out_valid !== 1'b0 || issued_count !== 16'd0 || out_msg !== '0)
      $display("FAIL areset_now: got lvl=%0d ov=%b cnt=%0d msg=%h expected all 0",
               level, out_valid, issued_count, out_msg);
    else passed++;
    tick;
    rst = 1;
  endtask

  initial begin
    test_reset;
    test_contention;
    test_backpressure;
    test_simul_push_pop;
    test_step_mode;
    test_wrap_and_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msg_scheduler.md
# msg_scheduler

Arbitrates 168-bit order messages from two sources (stimulus ROM feeder, host/UART receiver) into one buffered stream toward the sequencer/processor datapath. Round-robin on a valid/ready handshake per source. A DEPTH-entry FIFO decouples the sources from the consumer. An optional single-step mode releases one message per press of the `next_msg` button for bench/board debugging.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- MSG_W, 168: message width; payload is opaque to this block.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- src0_valid  in  1  source 0 (ROM feeder) has a message.
- src0_msg  in  MSG_W  source 0 message.
- src0_ready  out  1  source 0 message accepted this cycle when high with src0_valid.
- src1_valid  in  1  source 1 (host receiver) has a message.
- src1_msg  in  MSG_W  source 1 message.
- src1_ready  out  1  source 1 accept.
- step_mode  in  1  1 = single-step release; 0 = free-running.
- next_msg  in  1  asynchronous push-button; used only in step mode.
- out_valid  out  1  out_msg holds a releasable message.
- out_msg  out  MSG_W  head-of-FIFO message.
- out_ready  in  1  consumer accepts when high with out_valid.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- issued_count  out  16  messages delivered on the output; wraps 0xFFFF -> 0.

## Operation
- Arbitration, combinational each cycle. `full` is the registered FIFO-full flag.
  - Only one source valid: that source is granted.
  - Both valid: grant goes to the source not recorded in `last_grant`.
  - srcN_ready = grant==N && !full. A ready is never asserted to a source whose valid is low.
- `last_grant` register: reset value 1, so src0 wins the first contention. It updates to N only on an accepted transfer from source N.
- Push: an accepted source message is written at the tail on the same clock edge. At most one push per cycle.
- Pop: out_valid && out_ready advances the head on that edge and increments issued_count.
- FIFO: circular, with write and read pointers of $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
  - Simultaneous push and pop: level unchanged.
  - Full: no push, even if a pop occurs in the same cycle. Ready derives from registered `full`; there is no same-cycle slot reuse.
  - Empty: no bypass. A message pushed into an empty FIFO is visible on out_msg one cycle later.
- Step mode:
  - next_msg passes through a 2-flop synchronizer followed by a rising-edge detector, giving `press`.
  - `credit` is a 1-bit register.
    - press sets it; it saturates at 1, so extra presses while credit=1 are lost.
    - A pop clears it.
    - Press and pop in the same cycle: credit ends at 1.
  - out_valid = !empty && (!step_mode || credit).
  - With step_mode=0, credit is held at 0 and presses are ignored.
  - Changing step_mode takes effect in the same cycle; no message is lost or duplicated.
- out_msg reflects the head entry whenever the FIFO is non-empty, independent of out_valid.

## Timing
- Reset values:
  - src0_ready = 0, src1_ready = 0, out_valid = 0.
  - out_msg = 0, level = 0, issued_count = 0.
  - last_grant = 1, credit = 0, synchronizer flops = 0.
- Reset asserted mid-operation: all buffered messages are discarded immediately (asynchronously). No partial handshake completes.
- Source-to-output latency: 1 cycle minimum (push at edge t, out_valid high after t).
- Throughput: 1 message per cycle sustained when the FIFO is neither full nor empty and out_ready=1.
- Button-to-release latency in step mode: 3 cycles from a synchronous rising edge of next_msg to out_valid (2 synchronizer stages + edge register), given a non-empty FIFO.
- All outputs except src*_ready and out_valid are registered. Those two are combinational from registered state and srcN_valid; no path runs from out_ready to src*_ready.

## Test plan
- Reset and idle: hold rst=0 for 3 cycles, then release with no valids -> all outputs 0, level=0, and they stay so for 10 cycles.
- Contention: src0 and src1 both valid continuously, out_ready=1, step_mode=0 -> accepts alternate src0, src1, src0, …. out_msg order matches, and issued_count=8 after 8 pops.
- Backpressure/full: DEPTH=4, out_ready=0, src0 streams messages 0x1..0x6 -> level reaches 4 and src0_ready drops. Then one cycle of out_ready=1 -> 0x1 popped and level=3 that cycle. Push resumes the next cycle with message 0x5.
- Simultaneous push/pop at level 2 -> level stays 2 and FIFO order is preserved.
- Step mode: load 3 messages, step_mode=1, out_ready=1 -> out_valid stays 0. Each next_msg pulse releases exactly one message, 3 cycles after the pulse. Two pulses 4 cycles apart with no pop in between release only one message.
- Counter wrap and async reset: preset traffic so issued_count=0xFFFF, then one more pop -> 0x0000. Assert rst mid-stream at level 3 -> level and out_valid are 0 immediately, before the next clock edge.
